// File: rtl/led_fade_ctrl_if.sv
// Control/status bundle between a top-level controller and led_fade_ctrl.
//   START, STOP, REPEAT, HOLD_TICKS : requests and hold length from the controller
//   BUSY, DONE, LEVEL, LED          : sequencer status, brightness and PWM output
// master = controller side, slave = led_fade_ctrl side.
interface led_fade_ctrl_if #(
    parameter int LEVEL_W = 5,
    parameter int HOLD_W  = 8
);
    logic               START;
    logic               STOP;
    logic               REPEAT;
    logic [HOLD_W-1:0]  HOLD_TICKS;
    logic               BUSY;
    logic               DONE;
    logic [LEVEL_W-1:0] LEVEL;
    logic               LED;

    modport master (
        output START, STOP, REPEAT, HOLD_TICKS,
        input  BUSY, DONE, LEVEL, LED
    );

    modport slave (
        input  START, STOP, REPEAT, HOLD_TICKS,
        output BUSY, DONE, LEVEL, LED
    );
endinterface

// File: rtl/led_fade_ctrl.sv
// LED glow sequencer: steps a brightness level through rise, hold-high, fall
// and hold-low phases on a prescaled tick and feeds a first-order sigma-delta
// (accumulator carry) PWM stage that drives the LED.
// Ports:
//   CLK   : clock (only clock)
//   RST_N : asynchronous active-low reset
//   bus   : led_fade_ctrl_if.slave
//           START/STOP/REPEAT/HOLD_TICKS in, BUSY/DONE/LEVEL/LED out (all registered)
module led_fade_ctrl #(
    parameter int LEVEL_W  = 5,
    parameter int TICK_DIV = 65536,
    parameter int HOLD_W   = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    led_fade_ctrl_if.slave bus
);
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_ZERO = LEVEL_W'(0);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = {LEVEL_W{1'b1}};
    localparam logic [HOLD_W-1:0]  HOLD_ZERO  = HOLD_W'(0);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] level_nx_s;
    logic [HOLD_W-1:0]  hold_r;
    logic [HOLD_W-1:0]  hold_nx_s;
    logic [PRESC_W-1:0] presc_r;
    logic               presc_clr_s;
    logic               tick_s;
    logic               stop_pend_r;
    logic               stop_nx_s;
    logic               done_nx_s;
    logic               busy_r;
    logic               done_r;
    logic [LEVEL_W:0]   acc_r;

    assign tick_s = (presc_r == PRESC_LAST);

    // Next-state, level, hold counter and stop-pending decisions.
    always_comb begin
        state_nx_s  = state_r;
        level_nx_s  = level_r;
        hold_nx_s   = hold_r;
        stop_nx_s   = stop_pend_r;
        presc_clr_s = 1'b0;
        done_nx_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stop_nx_s = 1'b0;
                // STOP wins over a simultaneous START.
                if (bus.START && !bus.STOP) begin
                    state_nx_s  = ST_RISE;
                    presc_clr_s = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RISE: begin
                if (bus.STOP) begin
                    state_nx_s  = ST_FALL;
                    presc_clr_s = 1'b1;
                    stop_nx_s   = 1'b1;
                end else if (tick_s) begin
                    level_nx_s = level_r + LEVEL_ONE;
                    if (level_r == (LEVEL_MAX - LEVEL_ONE)) begin
                        state_nx_s = ST_HOLD_HI;
                        hold_nx_s  = bus.HOLD_TICKS;
                    end else begin
                        state_nx_s = ST_RISE;
                    end
                end else begin
                    state_nx_s = ST_RISE;
                end
            end
            ST_HOLD_HI: begin
                if (bus.STOP) begin
                    state_nx_s  = ST_FALL;
                    presc_clr_s = 1'b1;
                    stop_nx_s   = 1'b1;
                end else if (tick_s) begin
                    if (hold_r == HOLD_ZERO) begin
                        state_nx_s = ST_FALL;
                    end else begin
                        hold_nx_s = hold_r - HOLD_ONE;
                    end
                end else begin
                    state_nx_s = ST_HOLD_HI;
                end
            end
            ST_FALL: begin
                if (bus.STOP) begin
                    stop_nx_s = 1'b1;
                end else begin
                    stop_nx_s = stop_pend_r;
                end
                if (tick_s) begin
                    // A stop taken at level 0 leaves nothing to fall; go straight
                    // to hold-low instead of wrapping the level.
                    if (level_r == LEVEL_ZERO) begin
                        state_nx_s = ST_HOLD_LO;
                        hold_nx_s  = bus.HOLD_TICKS;
                    end else if (level_r == LEVEL_ONE) begin
                        level_nx_s = LEVEL_ZERO;
                        state_nx_s = ST_HOLD_LO;
                        hold_nx_s  = bus.HOLD_TICKS;
                    end else begin
                        level_nx_s = level_r - LEVEL_ONE;
                    end
                end else begin
                    state_nx_s = ST_FALL;
                end
            end
            ST_HOLD_LO: begin
                if (bus.STOP) begin
                    state_nx_s  = ST_IDLE;
                    presc_clr_s = 1'b1;
                    stop_nx_s   = 1'b0;
                    done_nx_s   = 1'b1;
                end else if (tick_s) begin
                    if (hold_r != HOLD_ZERO) begin
                        hold_nx_s = hold_r - HOLD_ONE;
                    end else if (bus.REPEAT && !stop_pend_r) begin
                        state_nx_s = ST_RISE;
                    end else begin
                        state_nx_s = ST_IDLE;
                        stop_nx_s  = 1'b0;
                        done_nx_s  = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_HOLD_LO;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                level_nx_s = LEVEL_ZERO;
                stop_nx_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state, level, hold counter and registered status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            level_r     <= LEVEL_ZERO;
            hold_r      <= HOLD_ZERO;
            stop_pend_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            level_r     <= level_nx_s;
            hold_r      <= hold_nx_s;
            stop_pend_r <= stop_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            done_r      <= done_nx_s;
        end
    end

    // Tick prescaler: parked at 0 in idle, restarted on START/STOP accept.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_r <= PRESC_W'(0);
        end else if (presc_clr_s || (state_r == ST_IDLE) || tick_s) begin
            presc_r <= PRESC_W'(0);
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Free-running sigma-delta accumulator; its carry is the LED bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_r <= {(LEVEL_W + 1){1'b0}};
        end else begin
            acc_r <= {1'b0, acc_r[LEVEL_W-1:0]} + {1'b0, level_r};
        end
    end

    assign bus.BUSY  = busy_r;
    assign bus.DONE  = done_r;
    assign bus.LEVEL = level_r;
    assign bus.LED   = acc_r[LEVEL_W];
endmodule

// File: tb/tb_led_fade_ctrl.sv
// Self-checking bench for led_fade_ctrl. Expected LEVEL/BUSY/DONE come from a
// phase-timeline model (plain arithmetic on tick counts); LED is checked as a
// density property over windows of constant level.
module tb_led_fade_ctrl;
    localparam int LW   = 3;
    localparam int TD   = 4;
    localparam int HW   = 8;
    localparam int MAXL = 7;
    localparam int TD2  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_fade_ctrl_if #(.LEVEL_W(LW), .HOLD_W(HW)) bus ();
    led_fade_ctrl_if #(.LEVEL_W(LW), .HOLD_W(HW)) bus2 ();

    led_fade_ctrl #(.LEVEL_W(LW), .TICK_DIV(TD), .HOLD_W(HW)) dut (
        .CLK(clk), .RST_N(rst_n), .bus(bus)
    );
    led_fade_ctrl #(.LEVEL_W(LW), .TICK_DIV(TD2), .HOLD_W(HW)) dut2 (
        .CLK(clk), .RST_N(rst_n), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;

    // model state for the current run
    int m_h, m_passes, m_stop, m_L, m_end, m_per;

    // Level after edge t (relative to START accept) of an uninterrupted pass.
    function automatic int base_level(input int t);
        if (t < TD * MAXL) return t / TD;
        else if (t < TD * (MAXL + m_h + 1)) return MAXL;
        else if (t < TD * (2 * MAXL + m_h + 1)) return MAXL - (t - TD * (MAXL + m_h + 1)) / TD;
        else return 0;
    endfunction

    function automatic int model_level(input int t);
        int k;
        if (t >= m_end) return 0;
        if (m_stop >= 0 && t >= m_stop) begin
            k = (t - m_stop) / TD;
            return (m_L > k) ? (m_L - k) : 0;
        end
        return base_level(t % m_per);
    endfunction

    task automatic run_fade(input string name, input int h, input int passes,
                            input int stop_s, input int dup_s);
        int  lvh[512];
        bit  ledh[512];
        int  exp_lv;
        int  ones;
        bit  same;
        logic eb, ed;
        m_h = h; m_passes = passes; m_stop = stop_s;
        m_per = TD * (2 * MAXL + 2 * h + 2);
        if (stop_s >= 0) begin
            m_L   = base_level(stop_s - 1);
            m_end = stop_s + m_L * TD + (h + 1) * TD;
        end else begin
            m_L   = 0;
            m_end = passes * m_per;
        end
        bus.HOLD_TICKS = HW'(h);
        bus.REPEAT     = (passes > 1);
        @(negedge clk);
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        for (int t = 0; t <= m_end + 4; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (passes > 1 && t == m_per) bus.REPEAT = 1'b0;
            exp_lv = model_level(t);
            eb = (t < m_end);
            ed = (t == m_end);
            checks++;
            if (bus.LEVEL !== LW'(exp_lv)) begin
                errors++;
                $display("FAIL %s level t=%0d got %0d exp %0d", name, t, bus.LEVEL, exp_lv);
            end
            checks++;
            if (bus.BUSY !== eb) begin
                errors++;
                $display("FAIL %s busy t=%0d got %b exp %b", name, t, bus.BUSY, eb);
            end
            checks++;
            if (bus.DONE !== ed) begin
                errors++;
                $display("FAIL %s done t=%0d got %b exp %b", name, t, bus.DONE, ed);
            end
            lvh[t]  = exp_lv;
            ledh[t] = bus.LED;
            if (t >= 8) begin
                same = 1'b1;
                for (int j = t - 8; j < t; j++) if (lvh[j] != lvh[t-8]) same = 1'b0;
                if (same) begin
                    ones = 0;
                    for (int j = t - 7; j <= t; j++) ones += int'(ledh[j]);
                    checks++;
                    if (ones != lvh[t-8]) begin
                        errors++;
                        $display("FAIL %s duty t=%0d got %0d highs exp %0d", name, t, ones, lvh[t-8]);
                    end
                end
            end
            bus.STOP  = (t + 1 == stop_s);
            bus.START = (t + 1 == dup_s);
        end
        bus.STOP  = 1'b0;
        bus.START = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.BUSY, bus.DONE, bus.LEVEL, bus.LED} !== 6'd0) begin
            errors++;
            $display("FAIL reset outputs got busy=%b done=%b level=%0d led=%b exp all 0",
                     bus.BUSY, bus.DONE, bus.LEVEL, bus.LED);
        end
    endtask

    task automatic test_single_fade();
        run_fade("single", 2, 1, -1, 10);
    endtask

    task automatic test_stop_hold_hi();
        run_fade("stop_hi", 2, 2, 34, -1);
    endtask

    task automatic test_repeat();
        run_fade("repeat", 2, 2, -1, -1);
    endtask

    task automatic test_idle_controls();
        @(negedge clk);
        bus.START = 1'b1;
        bus.STOP  = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        bus.STOP = 1'b1;
        @(negedge clk);
        bus.STOP = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.BUSY !== 1'b0 || bus.LEVEL !== 3'd0 || bus.DONE !== 1'b0) begin
                errors++;
                $display("FAIL idle_ctrl cyc=%0d got busy=%b level=%0d done=%b exp 0/0/0",
                         i, bus.BUSY, bus.LEVEL, bus.DONE);
            end
        end
    endtask

    task automatic test_duty_level4();
        bit led2[200];
        int ones;
        bus2.HOLD_TICKS = HW'(0);
        @(negedge clk);
        bus2.START = 1'b1;
        @(posedge clk);
        #1;
        bus2.START = 1'b0;
        for (int t = 1; t <= 160; t++) begin
            @(posedge clk);
            #1;
            led2[t] = bus2.LED;
            if (t == 140) begin
                checks++;
                if (bus2.LEVEL !== 3'd4) begin
                    errors++;
                    $display("FAIL duty4 level got %0d exp 4", bus2.LEVEL);
                end
            end
        end
        ones = 0;
        for (int t = 130; t < 138; t++) ones += int'(led2[t]);
        checks++;
        if (ones != 4) begin
            errors++;
            $display("FAIL duty4 highs got %0d exp 4", ones);
        end
        for (int t = 130; t <= 159; t++) begin
            checks++;
            if (led2[t] == led2[t-1]) begin
                errors++;
                $display("FAIL duty4 alternate t=%0d got %b exp %b", t, led2[t], ~led2[t-1]);
            end
        end
        @(negedge clk);
        bus2.STOP = 1'b1;
        @(negedge clk);
        bus2.STOP = 1'b0;
    endtask

    task automatic test_random();
        int h, p, s, d;
        for (int i = 0; i < 8; i++) begin
            h = int'($urandom_range(0, 3));
            p = int'($urandom_range(1, 2));
            s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(TD + 1, TD * (MAXL + h + 1) - 1)) : -1;
            d = int'($urandom_range(1, 12));
            run_fade("random", h, p, s, d);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.HOLD_TICKS = HW'(1);
        bus.REPEAT = 1'b0;
        bus.START = 1'b1;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (bus.LEVEL !== 3'd2 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL areset pre got level=%0d busy=%b exp 2/1", bus.LEVEL, bus.BUSY);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.BUSY, bus.DONE, bus.LEVEL, bus.LED} !== 6'd0) begin
            errors++;
            $display("FAIL areset outputs got busy=%b done=%b level=%0d led=%b exp all 0",
                     bus.BUSY, bus.DONE, bus.LEVEL, bus.LED);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.BUSY !== 1'b0 || bus.LEVEL !== 3'd0) begin
                errors++;
                $display("FAIL areset idle cyc=%0d got busy=%b level=%0d exp 0/0", i, bus.BUSY, bus.LEVEL);
            end
        end
        run_fade("after_reset", 1, 1, -1, -1);
    endtask

    initial begin
        bus.START = 1'b0; bus.STOP = 1'b0; bus.REPEAT = 1'b0; bus.HOLD_TICKS = HW'(0);
        bus2.START = 1'b0; bus2.STOP = 1'b0; bus2.REPEAT = 1'b0; bus2.HOLD_TICKS = HW'(0);
        test_reset();
        test_duty_level4();
        test_single_fade();
        test_stop_hold_hi();
        test_repeat();
        test_idle_controls();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_fade_ctrl.md
# led_fade_ctrl

Sequencer for the LED glow datapath on the TinyFPGA BX. It steps a brightness level through rise, hold-high, fall and hold-low phases on a prescaled tick, and drives a first-order sigma-delta (accumulator-carry) PWM stage that produces the LED output. `START`/`STOP` control lets a top level run one fade or loop fades and know when the LED is dark again. It sits between top-level control logic and the `LED` pin.

## Interface
- `LEVEL_W`, default 5: brightness width. MAX = 2^LEVEL_W − 1.
- `TICK_DIV`, default 65536: clock cycles per sequencer tick. Must be ≥ 2.
- `HOLD_W`, default 8: width of `HOLD_TICKS`.

Ports:
- `CLK`  in  1: 16 MHz clock. Only clock.
- `RST_N`  in  1: reset, asynchronous, active-low.
- `START`  in  1: start request, sampled on `CLK` rise.
- `STOP`  in  1: stop request, sampled on `CLK` rise.
- `REPEAT`  in  1: loop fades; sampled at the end of hold-low.
- `HOLD_TICKS`  in  HOLD_W: hold length; the phase lasts `HOLD_TICKS`+1 ticks.
- `BUSY`  out  1: high in any state except IDLE.
- `DONE`  out  1: one-cycle pulse when the sequence ends.
- `LEVEL`  out  LEVEL_W: current brightness.
- `LED`  out  1: sigma-delta PWM output.

## Operation
- **States:** IDLE, RISE, HOLD_HI, FALL, HOLD_LO. Reset puts the block in IDLE.
- **Prescaler:**
  - Counts 0..TICK_DIV−1 and wraps.
  - `tick` = (prescaler == TICK_DIV−1).
  - Cleared on START accept and on STOP accept.
  - Held at 0 in IDLE.
- **Hold counter:** loaded from `HOLD_TICKS` on entry to HOLD_HI or HOLD_LO. On `tick`: if 0, exit the state; else decrement.
- **Transitions:**
  - IDLE: `START`=1 and `STOP`=0 → RISE.
  - RISE, on `tick`: `LEVEL`++. If `LEVEL` was MAX−1 → HOLD_HI.
  - HOLD_HI: hold expiry → FALL.
  - FALL, on `tick`: `LEVEL`−−. If `LEVEL` was 1 → HOLD_LO.
  - HOLD_LO, on expiry:
    - `REPEAT`=1 and no stop pending → RISE.
    - Otherwise → IDLE and pulse `DONE`.
- **STOP:**
  - In RISE or HOLD_HI: next edge goes to FALL. `LEVEL` is kept and the prescaler is cleared. A stop-pending flag is set, which blocks repeat.
  - In FALL: only sets stop-pending.
  - In HOLD_LO: next edge goes to IDLE with `DONE`.
  - In IDLE: ignored. `START` and `STOP` in the same cycle in IDLE: STOP wins and the block stays idle.
  - Stop-pending clears on entry to IDLE.
- **START while BUSY:** ignored.
- **Sigma-delta:**
  - `acc` is LEVEL_W+1 bits: `acc <= acc[LEVEL_W-1:0] + LEVEL`.
  - `LED = acc[LEVEL_W]`.
  - `LED` high density = `LEVEL`/2^LEVEL_W. MAX gives (2^W−1)/2^W. 0 gives constantly low.
  - The accumulator free-runs in every state.
- **Arithmetic:** `LEVEL` never wraps. It is bounded to 0..MAX by the state logic.

## Timing
- **Reset values:**
  - `BUSY`=0, `DONE`=0, `LEVEL`=0, `LED`=0.
  - `acc`=0, prescaler=0, hold counter=0, stop-pending=0.
- **Reset mid-operation:** `RST_N` low clears all of the above immediately, without waiting for a `CLK` edge.
- **Outputs:** all registered. No combinational path from inputs to outputs.
- **START:** accepted on edge E. `BUSY`=1 after E. First `LEVEL` step at edge E+TICK_DIV.
- **Single fade length:** E + TICK_DIV·(2·MAX + 2·(HOLD_TICKS+1)) edges to the IDLE entry.
- **DONE:** high during the first cycle after the IDLE entry. `BUSY`=0 in that same cycle.
- **LED lag:** `LED` reflects a `LEVEL` change starting one cycle after it.
- **STOP:** takes effect at the first edge that samples it. The next step comes TICK_DIV cycles later.
- **REPEAT:** RISE restarts directly from HOLD_LO. `DONE` does not pulse and `BUSY` stays high.

## Test plan
Bench parameters: LEVEL_W=3, TICK_DIV=4, HOLD_TICKS=2, START at edge 0.

- **Single fade, REPEAT=0:**
  - `LEVEL` 1..7 at edges 4..28.
  - `LEVEL`=7 held until edge 40, then 6..0 at edges 44..68.
  - IDLE at edge 80. `DONE` pulse of exactly 1 cycle. `BUSY` high over edges 1..80.
- **Duty check:** sample `LED` over 8 cycles in HOLD_HI → 7 highs. Over 8 cycles in HOLD_LO → 0 highs. With `LEVEL` forced to 4 → 4 highs alternating.
- **STOP at edge 33 (HOLD_HI):**
  - FALL at edge 34, `LEVEL` stays 7.
  - 6 at edge 38, then down to 0 at edge 62.
  - IDLE with `DONE` at edge 74, even with REPEAT=1.
- **REPEAT=1:** second RISE starts at edge 80 with no `DONE` and `BUSY` continuously high. `LEVEL` reaches 1 at edge 84.
- **Edge cases:**
  - START at edge 10 while busy → no change to the timing.
  - START+STOP together in IDLE → `BUSY` stays 0.
  - STOP in IDLE → no effect.
- **Async reset:** drop `RST_N` mid-RISE, between clock edges → all outputs 0 immediately. After release, the block stays IDLE until a new START.
